// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - video timing outputs bundled toward the pattern source and TMDS encoder
interface video_timing_gen_if;
    logic        O_ready;
    logic        O_hs;
    logic        O_vs;
    logic        O_de;
    logic [11:0] O_x;
    logic [10:0] O_y;
    logic        O_frame_start;

    modport master (
        output O_ready, O_hs, O_vs, O_de, O_x, O_y, O_frame_start
    );

    modport slave (
        input  O_ready, O_hs, O_vs, O_de, O_x, O_y, O_frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - PLL lock qualification and HS/VS/DE/coordinate generation on the pixel clock
module video_timing_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1,
    parameter int LOCK_WAIT = 1024
) (
    input  logic                      I_pxl_clk,
    input  logic                      I_rst,
    input  logic                      I_pll_lock,
    video_timing_gen_if.master        vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          lock_meta_q;
    logic          lock_s_q;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [11:0]   h_cnt_q, h_cnt_d;
    logic [10:0]   v_cnt_q, v_cnt_d;
    logic          run_adv;

    logic          ready_q, ready_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [11:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic          fs_q, fs_d;

    // I_pll_lock comes from the PLL domain; only lock_s_q is used below
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= I_pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: if (lock_s_q) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:       if (!lock_s_q) state_d = ST_WAIT_LOCK;
            default:      state_d = ST_WAIT_LOCK;
        endcase
    end

    // Counters only move while RUN persists, so every entry into RUN starts at (0,0)
    always_comb begin
        run_adv    = (state_q == ST_RUN) && (state_d == ST_RUN);
        wait_cnt_d = '0;
        h_cnt_d    = '0;
        v_cnt_d    = '0;
        if ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (run_adv) begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
        end
    end

    always_comb begin
        ready_d = (state_d == ST_RUN);
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        de_d    = 1'b0;
        x_d     = '0;
        y_d     = '0;
        fs_d    = 1'b0;
        if (run_adv) begin
            de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            hs_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
            vs_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
            x_d  = de_d ? h_cnt_q : 12'd0;
            y_d  = de_d ? v_cnt_q : 11'd0;
            fs_d = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
        end
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            wait_cnt_q <= '0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            ready_q    <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            fs_q       <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            ready_q    <= ready_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fs_q       <= fs_d;
        end
    end

    assign vid.O_ready       = ready_q;
    assign vid.O_hs          = hs_q;
    assign vid.O_vs          = vs_q;
    assign vid.O_de          = de_q;
    assign vid.O_x           = x_q;
    assign vid.O_y           = y_q;
    assign vid.O_frame_start = fs_q;

endmodule
